fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction-granular fetch queue between the ICache and the decoder.
- Accepts FETCH_WIDTH-wide fetch packets with a per-lane valid mask. Valid lanes are compacted into a circular instruction store.
- Presents up to DECODE_WIDTH oldest instructions per cycle with their PCs.
- The decoder may consume any prefix count of the presented instructions, so partial packets (misaligned fetch, taken-branch truncation) and partial decode are both handled without bubbles.

Parameters:
- FETCH_WIDTH, 2, instructions per incoming packet (>=1).
- DECODE_WIDTH, 2, instructions presented per cycle (>=1).
- DEPTH, 16, instruction slots; power of two, >= 2*max(FETCH_WIDTH, DECODE_WIDTH).
- CPU_ADDR_BITS, 32, PC width.
- CPU_INST_BITS, 32, instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous queue clear (redirect)
- pc  in  CPU_ADDR_BITS  PC of packet lane 0
- icache_dout  in  FETCH_WIDTH*CPU_INST_BITS  packet; lane i at bits [i*CPU_INST_BITS +: CPU_INST_BITS]
- icache_lane_val  in  FETCH_WIDTH  per-lane valid mask; arbitrary pattern allowed
- icache_dout_val  in  1  packet valid
- fq_rdy  out  1  queue can accept a full packet
- dec_inst  out  DECODE_WIDTH*CPU_INST_BITS  presented instructions, oldest in lane 0
- dec_pc  out  DECODE_WIDTH*CPU_ADDR_BITS  PCs of presented instructions
- dec_val  out  DECODE_WIDTH  thermometer valid, lane i valid iff count > i
- dec_take  in  $clog2(DECODE_WIDTH+1)  number of presented instructions consumed this cycle
- fq_count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- State: storage of DEPTH {inst, pc} slots; rd_ptr and wr_ptr of width $clog2(DEPTH), wrapping modulo DEPTH; count register of width $clog2(DEPTH+1). Full and empty are decided from count, never from pointer compare.
- Reset (rst=1 at posedge): rd_ptr=wr_ptr=0, count=0. Slot contents are don't-care. Next-cycle outputs: dec_val=0, dec_inst=0, dec_pc=0, fq_count=0, fq_rdy=1.
- fq_rdy = (count <= DEPTH-FETCH_WIDTH) && !flush. It is independent of icache_dout_val; there is no combinational path from any input except flush.
- Enqueue: do_write = icache_dout_val && fq_rdy.
  - Valid lanes are written in ascending lane order to slots wr_ptr, wr_ptr+1, ... (mod DEPTH).
  - Stored pc for lane i = pc + 4*i, computed in CPU_ADDR_BITS with modulo wrap.
  - n_in = popcount(icache_lane_val); wr_ptr advances by n_in. A mask of all zeros writes nothing and leaves state unchanged.
- Presentation (combinational from state): lane j shows slot rd_ptr+j (mod DEPTH) when count > j. Lanes with dec_val[j]=0 drive dec_inst and dec_pc as 0.
- No write-through bypass: an instruction enqueued at edge N is visible from cycle N+1 onward.
- Dequeue:
  - n_out = min(dec_take, count, DECODE_WIDTH); rd_ptr advances by n_out.
  - dec_take > popcount(dec_val) is a protocol error. RTL clamps to the valid count; the bench asserts it never happens.
- Simultaneous enqueue and dequeue: count_next = count + n_in - n_out. Legal at any occupancy, including full-threshold and wrap-around.
- Flush (rst=0, flush=1):
  - Pointers and count go to 0 at the edge; any same-cycle write and read are dropped.
  - Combinationally during flush: dec_val=0 and fq_rdy=0.
- rst has priority over flush. Reset mid-operation discards all contents with no partial output.
- Wrap: packets that straddle slot DEPTH-1 -> 0 are split correctly; ordering is preserved across wrap.

Test Plan (defaults FETCH_WIDTH=2, DECODE_WIDTH=2, DEPTH=16):
- Reset then idle -> dec_val=00, fq_count=0, fq_rdy=1 for 5 cycles.
- Enqueue pc=0x100, insts {A,B}, mask 11, dec_take=0 -> next cycle dec_val=11, dec_pc={0x104,0x100}, fq_count=2.
- Enqueue pc=0x200, mask 10 (lane1=C only), then pc=0x300, mask 11 {D,E} -> C/0x204, D/0x300, E/0x304 appear in order; dec_take=1 each cycle yields C, D, E on lane 0 over three cycles.
- Fill with 7 full packets, no dequeue -> fq_count=14, fq_rdy=1. Eighth packet -> fq_count=16, fq_rdy=0. With icache_dout_val held, no write until dec_take=2 frees two slots; then fq_rdy=1 the following cycle.
- Steady stream: full packet every cycle with dec_take=2 for 40 cycles -> fq_count constant, pointers wrap at least 4 times, output PC sequence strictly +4 with no gaps or duplicates.
- With fq_count=6, assert flush together with a valid packet and dec_take=2 -> next cycle fq_count=0, dec_val=00, the flushed packet is absent; the next packet pc=0x400 appears at lane 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Purpose: compacts valid lanes of ICache fetch packets into a circular instruction store and presents the oldest DECODE_WIDTH entries to decode.
// Latency: an instruction written at edge N is presented from cycle N+1; there is no write-through bypass.
// Backpressure: fq_rdy drops when a full packet no longer fits or during flush; decode consumes any prefix count via dec_take.
module fetch_queue #(
    parameter int FETCH_WIDTH   = 2,
    parameter int DECODE_WIDTH  = 2,
    parameter int DEPTH         = 16,
    parameter int CPU_ADDR_BITS = 32,
    parameter int CPU_INST_BITS = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic [CPU_ADDR_BITS-1:0]                pc,
    input  logic [FETCH_WIDTH*CPU_INST_BITS-1:0]    icache_dout,
    input  logic [FETCH_WIDTH-1:0]                  icache_lane_val,
    input  logic                                    icache_dout_val,
    output logic                                    fq_rdy,
    output logic [DECODE_WIDTH*CPU_INST_BITS-1:0]   dec_inst,
    output logic [DECODE_WIDTH*CPU_ADDR_BITS-1:0]   dec_pc,
    output logic [DECODE_WIDTH-1:0]                 dec_val,
    input  logic [$clog2(DECODE_WIDTH+1)-1:0]       dec_take,
    output logic [$clog2(DEPTH+1)-1:0]              fq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // A full packet fits only while occupancy leaves FETCH_WIDTH free slots.
    localparam logic [CNT_W-1:0] RDY_LIMIT = CNT_W'(DEPTH - FETCH_WIDTH);
    localparam logic [CNT_W-1:0] DEC_MAX   = CNT_W'(DECODE_WIDTH);

    logic [CPU_INST_BITS-1:0] inst_q [DEPTH];
    logic [CPU_ADDR_BITS-1:0] pc_q   [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] n_in, n_out;
    logic [PTR_W-1:0] lane_slot [FETCH_WIDTH];
    logic [PTR_W-1:0] lane_off;
    logic             do_write;

    // Ready depends only on state and flush so the ICache never sees a loop through valid.
    assign fq_rdy   = (count_q <= RDY_LIMIT) && !flush;
    assign do_write = icache_dout_val && fq_rdy;
    assign fq_count = count_q;

    // Compaction: each valid lane lands at wr_ptr plus the number of valid lanes below it.
    always_comb begin
        n_in     = '0;
        lane_off = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_slot[i] = wr_ptr_q + lane_off;
            if (icache_lane_val[i]) begin
                lane_off = lane_off + PTR_W'(1);
                n_in     = n_in + CNT_W'(1);
            end
        end
    end

    // Presentation: lane j shows the j-th oldest entry; invalid lanes are driven to zero.
    always_comb begin
        dec_val  = '0;
        dec_inst = '0;
        dec_pc   = '0;
        for (int j = 0; j < DECODE_WIDTH; j++) begin
            if (!flush && (count_q > CNT_W'(j))) begin
                dec_val[j]                                    = 1'b1;
                dec_inst[j*CPU_INST_BITS +: CPU_INST_BITS]    = inst_q[rd_ptr_q + PTR_W'(j)];
                dec_pc[j*CPU_ADDR_BITS +: CPU_ADDR_BITS]      = pc_q[rd_ptr_q + PTR_W'(j)];
            end
        end
    end

    // Dequeue amount is clamped to what is actually present so a bad dec_take cannot underflow.
    always_comb begin
        n_out = CNT_W'(dec_take);
        if (n_out > count_q) begin
            n_out = count_q;
        end
        if (n_out > DEC_MAX) begin
            n_out = DEC_MAX;
        end
    end

    // Next-state pointers and occupancy; flush drops any same-cycle read and write.
    always_comb begin
        rd_ptr_d = rd_ptr_q + n_out[PTR_W-1:0];
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q - n_out;
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + n_in[PTR_W-1:0];
            count_d  = count_d + n_in;
        end
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers; reset wins over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot storage: contents are meaningless outside [rd_ptr, rd_ptr+count), so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (icache_lane_val[i]) begin
                    inst_q[lane_slot[i]] <= icache_dout[i*CPU_INST_BITS +: CPU_INST_BITS];
                    pc_q[lane_slot[i]]   <= pc + CPU_ADDR_BITS'(4*i);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Purpose: exercises fetch_queue with directed scenarios and random traffic against a queue-based reference.
// Latency: outputs are compared once per cycle, shortly after new inputs are applied on the falling edge.
// Backpressure: random decode takes never exceed the presented count; packets offered while not ready are dropped by the model.
module tb_fetch_queue;

    localparam int FW    = 2;
    localparam int DW    = 2;
    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] pc;
    logic [63:0] icache_dout;
    logic [1:0]  icache_lane_val;
    logic        icache_dout_val;
    logic        fq_rdy;
    logic [63:0] dec_inst;
    logic [63:0] dec_pc;
    logic [1:0]  dec_val;
    logic [1:0]  dec_take;
    logic [4:0]  fq_count;

    fetch_queue #(
        .FETCH_WIDTH   (FW),
        .DECODE_WIDTH  (DW),
        .DEPTH         (DEPTH),
        .CPU_ADDR_BITS (32),
        .CPU_INST_BITS (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .pc              (pc),
        .icache_dout     (icache_dout),
        .icache_lane_val (icache_lane_val),
        .icache_dout_val (icache_dout_val),
        .fq_rdy          (fq_rdy),
        .dec_inst        (dec_inst),
        .dec_pc          (dec_pc),
        .dec_val         (dec_val),
        .dec_take        (dec_take),
        .fq_count        (fq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode must never take more than it was shown (flush hides everything, so it is exempt).
    always @(posedge clk) begin
        if (!rst && !flush) begin
            assert (32'(dec_take) <= $countones(dec_val));
        end
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t mq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int visible();
        return (mq.size() < DW) ? mq.size() : DW;
    endfunction

    // One clock: apply inputs at the falling edge, compare against the reference, advance the reference.
    task automatic cycle(input logic r, input logic fl, input logic [31:0] p, input logic [63:0] d,
                         input logic [1:0] m, input logic dv, input int take);
        logic [63:0] e_inst;
        logic [63:0] e_pc;
        logic [1:0]  e_val;
        logic        e_rdy;
        int          n_out;
        ent_t        e;
        rst             = r;
        flush           = fl;
        pc              = p;
        icache_dout     = d;
        icache_lane_val = m;
        icache_dout_val = dv;
        dec_take        = 2'(take);
        #1;
        e_rdy  = (mq.size() <= DEPTH - FW) && !fl;
        e_val  = '0;
        e_inst = '0;
        e_pc   = '0;
        for (int j = 0; j < DW; j++) begin
            if (!fl && mq.size() > j) begin
                e_val[j]          = 1'b1;
                e_inst[j*32 +: 32] = mq[j].inst;
                e_pc[j*32 +: 32]   = mq[j].pc;
            end
        end
        chk("dec_val",  64'(dec_val),  64'(e_val));
        chk("dec_inst", dec_inst,      e_inst);
        chk("dec_pc",   dec_pc,        e_pc);
        chk("fq_count", 64'(fq_count), 64'(mq.size()));
        chk("fq_rdy",   64'(fq_rdy),   64'(e_rdy));
        if (r || fl) begin
            mq.delete();
        end else begin
            n_out = take;
            if (n_out > mq.size()) n_out = mq.size();
            if (n_out > DW) n_out = DW;
            repeat (n_out) void'(mq.pop_front());
            if (dv && e_rdy) begin
                for (int i = 0; i < FW; i++) begin
                    if (m[i]) begin
                        e.inst = d[i*32 +: 32];
                        e.pc   = p + 32'(4*i);
                        mq.push_back(e);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_seq [3];
        logic [31:0] rp;
        logic        rfl;
        logic        rrst;
        exp_seq[0] = 32'hCCCC0003;
        exp_seq[1] = 32'hDDDD0004;
        exp_seq[2] = 32'hEEEE0005;

        rst = 1'b1; flush = 1'b0; pc = '0; icache_dout = '0;
        icache_lane_val = '0; icache_dout_val = 1'b0; dec_take = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset then idle.
        repeat (5) begin
            cycle(0, 0, 32'h0, 64'h0, 2'b00, 0, 0);
            chk("idle_cnt", 64'(fq_count), 64'd0);
            chk("idle_rdy", 64'(fq_rdy),   64'd1);
            chk("idle_val", 64'(dec_val),  64'd0);
        end

        // Single full packet becomes visible the next cycle.
        cycle(0, 0, 32'h100, {32'hBBBB0002, 32'hAAAA0001}, 2'b11, 1, 0);
        chk("pkt_val", 64'(dec_val),  64'h3);
        chk("pkt_pc",  dec_pc,        {32'h104, 32'h100});
        chk("pkt_cnt", 64'(fq_count), 64'd2);
        cycle(0, 0, 32'h0, 64'h0, 2'b00, 0, 2);

        // Partial packet followed by a full one; drained one at a time.
        cycle(0, 0, 32'h200, {32'hCCCC0003, 32'h99990000}, 2'b10, 1, 0);
        cycle(0, 0, 32'h300, {32'hEEEE0005, 32'hDDDD0004}, 2'b11, 1, 0);
        chk("part_pc", dec_pc, {32'h300, 32'h204});
        for (int k = 0; k < 3; k++) begin
            chk("part_seq", 64'(dec_inst[31:0]), 64'(exp_seq[k]));
            cycle(0, 0, 32'h0, 64'h0, 2'b00, 0, 1);
        end
        chk("part_empty", 64'(fq_count), 64'd0);

        // Fill to the ready threshold and beyond.
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 32'h2000 + 32'(8*k), {32'(k*2+1), 32'(k*2)}, 2'b11, 1, 0);
            if (k == 6) begin
                chk("fill7_cnt", 64'(fq_count), 64'd14);
                chk("fill7_rdy", 64'(fq_rdy),   64'd1);
            end
        end
        chk("fill8_cnt", 64'(fq_count), 64'd16);
        chk("fill8_rdy", 64'(fq_rdy),   64'd0);
        repeat (2) cycle(0, 0, 32'h3000, 64'h1234, 2'b11, 1, 0);
        chk("hold_cnt", 64'(fq_count), 64'd16);
        cycle(0, 0, 32'h3000, 64'h1234, 2'b11, 1, 2);
        chk("free_cnt", 64'(fq_count), 64'd14);
        chk("free_rdy", 64'(fq_rdy),   64'd1);
        cycle(0, 0, 32'h3000, 64'h1234, 2'b11, 1, 0);
        chk("refill_cnt", 64'(fq_count), 64'd16);
        cycle(0, 1, 32'h0, 64'h0, 2'b00, 0, 0);

        // Steady stream: one packet in, two instructions out every cycle.
        cycle(0, 0, 32'h1000, {32'h5001, 32'h5000}, 2'b11, 1, 0);
        for (int k = 0; k < 40; k++) begin
            cycle(0, 0, 32'h1008 + 32'(8*k), {32'(k+7), 32'(k+3)}, 2'b11, 1, 2);
            chk("strm_cnt", 64'(fq_count), 64'd2);
            chk("strm_pc",  dec_pc, {32'h1004 + 32'(8*(k+1)), 32'h1000 + 32'(8*(k+1))});
        end
        cycle(0, 1, 32'h0, 64'h0, 2'b00, 0, 0);

        // Flush drops contents and the same-cycle packet.
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 32'h600 + 32'(8*k), {32'(k+40), 32'(k+20)}, 2'b11, 1, 0);
        end
        chk("pre_flush_cnt", 64'(fq_count), 64'd6);
        cycle(0, 1, 32'h500, {32'hF00D0001, 32'hF00D0000}, 2'b11, 1, 2);
        cycle(0, 0, 32'h400, {32'h40400001, 32'h40400000}, 2'b11, 1, 0);
        chk("post_flush_pc",  64'(dec_pc[31:0]), 64'h400);
        chk("post_flush_cnt", 64'(fq_count),     64'd2);

        // Random traffic, including wrap, partial masks, flushes and resets.
        for (int k = 0; k < 600; k++) begin
            rp   = 32'($urandom) & 32'hFFFF_FFFC;
            rfl  = ($urandom_range(24, 0) == 0);
            rrst = ($urandom_range(99, 0) == 0);
            cycle(rrst, rfl, rp, {32'($urandom), 32'($urandom)},
                  2'($urandom_range(3, 0)), 1'($urandom_range(3, 0) != 0),
                  rfl ? int'($urandom_range(2, 0)) : int'($urandom_range(visible(), 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
